// File: rtl/stack_calc_p.sv
// Stack calculator: T held in a register over a DEPTH-1 word RAM; push and ops finish on the accepting edge.
// `STACK_CALC_DIV_EN adds a restoring divider on op 111 (in_ready low W cycles); otherwise op 111 pops.
module stack_calc_p #(
  parameter int W     = 16,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         push,
  input  logic [2:0]   op,
  input  logic [W-1:0] d,
  input  logic         clr,
  output logic [W-1:0] out,
  output logic [AW:0]  cnt,
  output logic [2:0]   err
);
  localparam logic [2:0] OP_GT   = 3'b000;
  localparam logic [2:0] OP_NEG  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_SWAP = 3'b100;
  localparam logic [2:0] OP_PICK = 3'b101;
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [W-1:0]  r_top;
  logic [AW:0]   r_cnt;
  logic [2:0]    r_err;
  logic [W-1:0]  r_ram [0:DEPTH-2];

  logic          w_acc, w_n1, w_n2, w_full, w_pick_ok;
  logic [AW-1:0] w_n_addr, w_t_addr, w_pick_addr, w_rd_addr, w_wa;
  logic [AW:0]   w_t_lo, w_cnt_nxt;
  logic [W-1:0]  w_nos, w_top_nxt, w_wd;
  logic [2:0]    w_eset;
  logic          w_we, w_div_go;

  assign w_acc  = in_valid & in_ready;
  assign w_n1   = (r_cnt != '0);
  assign w_n2   = (r_cnt >= (AW+1)'(2));
  assign w_full = (r_cnt == C_DEPTH);

  // RAM slot i holds stack element i (0 = bottom); N lives at n-2, the next free slot for old T is n-1.
  assign w_n_addr    = w_n2 ? AW'(r_cnt - 2'd2) : '0;
  assign w_t_addr    = w_n1 ? AW'(r_cnt - 1'b1) : '0;
  assign w_t_lo      = (AW+1)'(r_top);
  assign w_pick_ok   = w_n2 && !r_top[W-1] && (33'(r_top) <= (33'(r_cnt) - 33'd2));
  assign w_pick_addr = w_pick_ok ? AW'(r_cnt - 2'd2 - w_t_lo) : '0;
  assign w_rd_addr   = (op == OP_PICK) ? w_pick_addr : w_n_addr;
  assign w_nos       = r_ram[w_rd_addr];

`ifdef STACK_CALC_DIV_EN
  localparam logic [2:0] OP_DIV = 3'b111;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int SW = $clog2(W);

  logic [1:0]    r_state;
  logic [W-1:0]  r_quo, r_dvs, r_rem;
  logic          r_neg;
  logic [SW-1:0] r_step;
  logic [W:0]    w_sh;
  logic          w_ge;
  logic [W-1:0]  w_rem_nxt, w_quo_nxt, w_div_res;

  // One restoring step per cycle; the last of the W steps is folded into DONE's write-back.
  assign w_sh      = {r_rem, r_quo[W-1]};
  assign w_ge      = (w_sh >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? W'(w_sh - {1'b0, r_dvs}) : W'(w_sh);
  assign w_quo_nxt = {r_quo[W-2:0], w_ge};
  assign w_div_res = r_neg ? -w_quo_nxt : w_quo_nxt;
  assign in_ready  = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_neg   <= 1'b0;
      r_step  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_div_go) begin
          r_quo   <= w_nos[W-1] ? -w_nos : w_nos;
          r_dvs   <= r_top[W-1] ? -r_top : r_top;
          r_rem   <= '0;
          r_neg   <= w_nos[W-1] ^ r_top[W-1];
          r_step  <= SW'(W-2);
          r_state <= S_DIV;
        end
        S_DIV: begin
          r_quo <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          if (r_step == '0) r_state <= S_DONE;
          else              r_step  <= r_step - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign in_ready = 1'b1;
`endif

  always_comb begin
    w_top_nxt = r_top;
    w_cnt_nxt = r_cnt;
    w_eset    = '0;
    w_we      = 1'b0;
    w_wa      = w_n_addr;
    w_wd      = r_top;
    w_div_go  = 1'b0;
`ifdef STACK_CALC_DIV_EN
    if (r_state == S_DONE) begin
      w_top_nxt = w_div_res;
      w_cnt_nxt = r_cnt - 1'b1;
    end
`endif
    if (w_acc) begin
      if (push) begin
        if (w_full) w_eset[0] = 1'b1;
        else begin
          w_top_nxt = d;
          w_cnt_nxt = r_cnt + 1'b1;
          w_we      = w_n1;
          w_wa      = w_t_addr;
        end
      end else begin
        case (op)
          OP_GT:   if (w_n1) w_top_nxt = (!r_top[W-1] && r_top != '0) ? W'(1) : '0;
                   else      w_eset[1] = 1'b1;
          OP_NEG:  if (w_n1) w_top_nxt = -r_top;
                   else      w_eset[1] = 1'b1;
          OP_ADD:  if (w_n2) begin w_top_nxt = w_nos + r_top; w_cnt_nxt = r_cnt - 1'b1; end
                   else      w_eset[1] = 1'b1;
          OP_MUL:  if (w_n2) begin w_top_nxt = w_nos * r_top; w_cnt_nxt = r_cnt - 1'b1; end
                   else      w_eset[1] = 1'b1;
          OP_SWAP: if (w_n2) begin w_top_nxt = w_nos; w_we = 1'b1; end
                   else      w_eset[1] = 1'b1;
          OP_PICK: if (w_pick_ok) w_top_nxt = w_nos;
                   else           w_eset[1] = 1'b1;
`ifdef STACK_CALC_DIV_EN
          OP_DIV:  if (!w_n2)             w_eset[1] = 1'b1;
                   else if (r_top == '0) w_eset[2] = 1'b1;
                   else                  w_div_go  = 1'b1;
`endif
          default: if (w_n1) begin
                     w_top_nxt = w_n2 ? w_nos : '0;
                     w_cnt_nxt = r_cnt - 1'b1;
                   end else w_eset[1] = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_ram[w_wa] <= w_wd;
  end

  // A fresh error in the same cycle as clr still lands.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_top <= '0;
      r_cnt <= '0;
      r_err <= '0;
    end else begin
      r_top <= w_top_nxt;
      r_cnt <= w_cnt_nxt;
      r_err <= (clr ? 3'b000 : r_err) | w_eset;
    end
  end

  assign out = r_top;
  assign cnt = r_cnt;
  assign err = r_err;
endmodule

// File: tb/tb_stack_calc_p.sv
// Directed vectors for stack_calc_p with hand-computed results; div checks only with STACK_CALC_DIV_EN.
module tb_stack_calc_p;
  localparam int W     = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam logic [2:0] GT = 3'd0, NEG = 3'd1, ADD = 3'd2, MUL = 3'd3,
                         SWP = 3'd4, PICK = 3'd5, POP = 3'd6, OP7 = 3'd7;

  logic         clk = 1'b0;
  logic         nrst, in_valid, push, clr;
  logic [2:0]   op;
  logic [W-1:0] d;
  logic         in_ready;
  logic [W-1:0] out;
  logic [AW:0]  cnt;
  logic [2:0]   err;
  int           n_vec = 0;
  int           n_miscmp = 0;

  stack_calc_p #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .push(push), .op(op), .d(d), .clr(clr), .out(out), .cnt(cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmd(input logic p, input logic [2:0] o, input logic [W-1:0] v);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check_vec("rdy_timeout", 32'(in_ready), 32'd1);
    push = p; op = o; d = v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic psh(input logic [W-1:0] v);
    cmd(1'b1, 3'd0, v);
  endtask

  task automatic opx(input logic [2:0] o);
    cmd(1'b0, o, '0);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    nrst = 1'b0; in_valid = 1'b0; push = 1'b0; op = '0; d = '0; clr = 1'b0;
    #12;
    check_vec("rst_cnt", 32'(cnt), 32'd0);
    check_vec("rst_out", 32'(out), 32'd0);
    check_vec("rst_err", 32'(err), 32'd0);
    check_vec("rst_rdy", 32'(in_ready), 32'd1);
    @(negedge clk); nrst = 1'b1;

    psh(16'd3); psh(16'd4); opx(ADD);
    check_vec("add_out", 32'(out), 32'd7);
    check_vec("add_cnt", 32'(cnt), 32'd1);
    check_vec("add_err", 32'(err), 32'd0);
    opx(POP);
    check_vec("pop1_out", 32'(out), 32'd0);
    check_vec("pop1_cnt", 32'(cnt), 32'd0);

    psh(16'd5); opx(NEG);
    check_vec("neg_out", 32'(out), 32'hFFFB);
    opx(GT);
    check_vec("gt_neg", 32'(out), 32'd0);
    psh(16'd2); opx(GT);
    check_vec("gt_pos", 32'(out), 32'd1);
    check_vec("gt_cnt", 32'(cnt), 32'd2);
    opx(POP); opx(POP);
    opx(POP);
    check_vec("empty_pop_err", 32'(err), 32'b010);
    check_vec("empty_pop_cnt", 32'(cnt), 32'd0);
    pulse_clr();
    check_vec("clr_err", 32'(err), 32'd0);

    psh(16'hFFFD); psh(16'd7); opx(MUL);
    check_vec("mul_out", 32'(out), 32'hFFEB);
    check_vec("mul_cnt", 32'(cnt), 32'd1);
    psh(16'd9); opx(SWP);
    check_vec("swap_out", 32'(out), 32'hFFEB);
    check_vec("swap_cnt", 32'(cnt), 32'd2);
    opx(POP);
    check_vec("swap_below", 32'(out), 32'd9);
    psh(16'h4000); opx(MUL);
    check_vec("mul_wrap", 32'(out), 32'h4000);
    opx(SWP);
    check_vec("swap1_err", 32'(err), 32'b010);
    check_vec("swap1_out", 32'(out), 32'h4000);
    check_vec("swap1_cnt", 32'(cnt), 32'd1);
    clr = 1'b1; opx(SWP); clr = 1'b0;
    check_vec("clr_vs_err", 32'(err), 32'b010);
    pulse_clr();
    opx(POP);
    psh(16'h7FFF); psh(16'd1); opx(ADD);
    check_vec("add_wrap", 32'(out), 32'h8000);
    opx(POP);
    check_vec("empty_again", 32'(cnt), 32'd0);

    psh(16'd10); psh(16'd20); psh(16'd30); psh(16'd1); opx(PICK);
    check_vec("pick_out", 32'(out), 32'd20);
    check_vec("pick_cnt", 32'(cnt), 32'd4);
    psh(16'd5); opx(PICK);
    check_vec("pick_range_err", 32'(err), 32'b010);
    check_vec("pick_range_out", 32'(out), 32'd5);
    check_vec("pick_range_cnt", 32'(cnt), 32'd5);
    pulse_clr();
    psh(16'd0); opx(PICK);
    check_vec("pick0_out", 32'(out), 32'd5);
    psh(16'd5); opx(PICK);
    check_vec("pick_max_out", 32'(out), 32'd10);
    check_vec("pick_max_err", 32'(err), 32'd0);
    psh(16'hFFFF); opx(PICK);
    check_vec("pick_neg_err", 32'(err), 32'b010);
    check_vec("pick_neg_out", 32'(out), 32'hFFFF);
    pulse_clr();
    for (int i = 0; i < 8; i++) opx(POP);
    check_vec("drain_cnt", 32'(cnt), 32'd0);

    for (int i = 0; i < DEPTH; i++) psh(16'(i));
    check_vec("full_cnt", 32'(cnt), 32'(DEPTH));
    check_vec("full_out", 32'(out), 32'(DEPTH - 1));
    psh(16'hABCD);
    check_vec("ovf_err", 32'(err), 32'b001);
    check_vec("ovf_cnt", 32'(cnt), 32'(DEPTH));
    check_vec("ovf_out", 32'(out), 32'(DEPTH - 1));
    pulse_clr();
    check_vec("ovf_clr", 32'(err), 32'd0);
    opx(POP);
    check_vec("full_pop_out", 32'(out), 32'(DEPTH - 2));
    check_vec("full_pop_cnt", 32'(cnt), 32'(DEPTH - 1));
    @(negedge clk); nrst = 1'b0; #1;
    check_vec("arst_cnt", 32'(cnt), 32'd0);
    check_vec("arst_out", 32'(out), 32'd0);
    @(negedge clk); nrst = 1'b1;

`ifdef STACK_CALC_DIV_EN
    psh(16'd5); opx(OP7);
    check_vec("div_n1_err", 32'(err), 32'b010);
    check_vec("div_n1_cnt", 32'(cnt), 32'd1);
    pulse_clr(); opx(POP);
    psh(16'hFFF9); psh(16'd2); opx(OP7);
    wait_ready(cyc);
    check_vec("div_busy_cycles", 32'(cyc), 32'd16);
    check_vec("div_out", 32'(out), 32'hFFFD);
    check_vec("div_cnt", 32'(cnt), 32'd1);
    psh(16'd0); opx(OP7);
    check_vec("div0_err", 32'(err), 32'b100);
    check_vec("div0_cnt", 32'(cnt), 32'd2);
    check_vec("div0_rdy", 32'(in_ready), 32'd1);
    pulse_clr(); opx(POP); opx(POP);
    psh(16'h8000); psh(16'hFFFF); opx(OP7);
    wait_ready(cyc);
    check_vec("div_ovf_out", 32'(out), 32'h8000);
    check_vec("div_ovf_err", 32'(err), 32'd0);
    psh(16'd3); opx(OP7);
    repeat (4) @(posedge clk);
    #2; nrst = 1'b0; #1;
    check_vec("div_rst_cnt", 32'(cnt), 32'd0);
    check_vec("div_rst_out", 32'(out), 32'd0);
    check_vec("div_rst_err", 32'(err), 32'd0);
    check_vec("div_rst_rdy", 32'(in_ready), 32'd1);
    @(negedge clk); nrst = 1'b1;
`else
    psh(16'd8); psh(16'd9); opx(OP7);
    check_vec("op7_pop_out", 32'(out), 32'd8);
    check_vec("op7_pop_cnt", 32'(cnt), 32'd1);
    check_vec("op7_rdy", 32'(in_ready), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule
